// File: rtl/n64vi_tx.sv
// N64 VI bus transmitter: one-entry pixel buffer feeding a four-phase
// (sync, R, G, B) slot sequencer that drives nDSYNC/D on every VCLK edge.
module n64vi_tx #(
   parameter logic [3:0] SYNC_IDLE = 4'b1111
) (
   input  logic       VCLK_i,
   input  logic       RST_i,
   input  logic [6:0] R_i,
   input  logic [6:0] G_i,
   input  logic [6:0] B_i,
   input  logic [3:0] SYNC_i,
   input  logic       pix_valid_i,
   output logic       pix_ready_o,
   output logic       nDSYNC_o,
   output logic [6:0] D_o,
   output logic       underflow_o
);

   typedef enum logic [1:0] {
      PH_SYNC = 2'd0,
      PH_R    = 2'd1,
      PH_G    = 2'd2,
      PH_B    = 2'd3
   } phase_t;

   phase_t phase, phase_nxt;

   logic       vld_p0;
   logic [6:0] r_p0, g_p0, b_p0;
   logic [3:0] sync_p0;

   logic [6:0] r_p1, g_p1, b_p1;
   logic [3:0] sync_p1;

   logic       accept;
   logic [6:0] ld_r, ld_g, ld_b;
   logic [3:0] ld_sync;

   assign pix_ready_o = ~vld_p0 & ~RST_i;
   assign accept      = pix_valid_i & pix_ready_o;

   always_ff @(posedge VCLK_i) begin
      if (RST_i) phase <= PH_SYNC;
      else       phase <= phase_nxt;
   end

   always_comb begin
      phase_nxt = phase;
      unique case (phase)
         PH_SYNC: phase_nxt = PH_R;
         PH_R:    phase_nxt = PH_G;
         PH_G:    phase_nxt = PH_B;
         PH_B:    phase_nxt = PH_SYNC;
      endcase
   end

   // stage p0: input buffer; a pixel accepted on a sync edge waits for the next slot
   always_ff @(posedge VCLK_i) begin
      if (RST_i)                            vld_p0 <= 1'b0;
      else if (phase == PH_SYNC && vld_p0)  vld_p0 <= 1'b0;
      else if (accept)                      vld_p0 <= 1'b1;
   end

   always_ff @(posedge VCLK_i) begin
      if (accept) begin
         r_p0    <= R_i;
         g_p0    <= G_i;
         b_p0    <= B_i;
         sync_p0 <= SYNC_i;
      end
   end

   // an empty buffer at slot start sends black and repeats the last sync nibble
   always_comb begin
      ld_r    = vld_p0 ? r_p0 : 7'd0;
      ld_g    = vld_p0 ? g_p0 : 7'd0;
      ld_b    = vld_p0 ? b_p0 : 7'd0;
      ld_sync = vld_p0 ? sync_p0 : sync_p1;
   end

   // stage p1: slot word and registered bus outputs
   always_ff @(posedge VCLK_i) begin
      if (RST_i) begin
         sync_p1     <= SYNC_IDLE;
         nDSYNC_o    <= 1'b1;
         D_o         <= 7'd0;
         underflow_o <= 1'b0;
      end else begin
         unique case (phase)
            PH_SYNC: begin
               r_p1     <= ld_r;
               g_p1     <= ld_g;
               b_p1     <= ld_b;
               sync_p1  <= ld_sync;
               nDSYNC_o <= 1'b0;
               D_o      <= {3'b000, ld_sync};
               if (!vld_p0) underflow_o <= 1'b1;
            end
            PH_R: begin
               nDSYNC_o <= 1'b1;
               D_o      <= r_p1;
            end
            PH_G: begin
               nDSYNC_o <= 1'b1;
               D_o      <= g_p1;
            end
            PH_B: begin
               nDSYNC_o <= 1'b1;
               D_o      <= b_p1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_n64vi_tx.sv
// Bench for n64vi_tx: directed vector table, then held-valid and random-valid
// runs scored against a slot-level reference model.
module tb_n64vi_tx;

   logic VCLK_w = 1'b0;
   always #5 VCLK_w = ~VCLK_w;

   logic       rst = 1'b1;
   logic       pix_valid = 1'b0;
   logic [6:0] r = '0, g = '0, b = '0;
   logic [3:0] sync = '0;
   logic       pix_ready, nDSYNC, underflow;
   logic [6:0] d;

   int checks = 0;
   int errors = 0;

   n64vi_tx dut (
      .VCLK_i      (VCLK_w),
      .RST_i       (rst),
      .R_i         (r),
      .G_i         (g),
      .B_i         (b),
      .SYNC_i      (sync),
      .pix_valid_i (pix_valid),
      .pix_ready_o (pix_ready),
      .nDSYNC_o    (nDSYNC),
      .D_o         (d),
      .underflow_o (underflow)
   );

   typedef struct {
      logic       rst;
      logic       vld;
      logic [6:0] r, g, b;
      logic [3:0] sync;
      logic       ready;
      logic       nd;
      logic [6:0] d;
      logic       uf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // inputs change on the falling edge; ready is sampled before the rising edge
   task automatic drive(input logic rs, input logic v, input logic [6:0] rr,
                        input logic [6:0] gg, input logic [6:0] bb, input logic [3:0] ss);
      @(negedge VCLK_w);
      rst = rs; pix_valid = v; r = rr; g = gg; b = bb; sync = ss;
      #1;
   endtask

   task automatic edge_wait();
      @(posedge VCLK_w);
      #1;
   endtask

   task automatic add(input logic rs, input logic v, input logic [6:0] rr, input logic [6:0] gg,
                      input logic [6:0] bb, input logic [3:0] ss, input logic rdy,
                      input logic nd, input logic [6:0] dd, input logic uf);
      vec_t x;
      x.rst = rs; x.vld = v; x.r = rr; x.g = gg; x.b = bb; x.sync = ss;
      x.ready = rdy; x.nd = nd; x.d = dd; x.uf = uf;
      vecs.push_back(x);
   endtask

   // Reference model run; must start right after a reset edge (phase 0 next).
   task automatic model_run(input int n_edges, input bit rnd, input string tag, output int dut_acc);
      logic       m_full, m_uf, v, exp_rdy, exp_nd;
      logic [6:0] m_r, m_g, m_b, s_r, s_g, s_b, pr, pg, pb, exp_d;
      logic [3:0] m_s, s_s, m_last, ps;
      int         idx, ph;
      m_full = 1'b0; m_uf = 1'b0; m_last = 4'hF; idx = 0; ph = 0; dut_acc = 0;
      m_r = '0; m_g = '0; m_b = '0; m_s = '0; s_r = '0; s_g = '0; s_b = '0; s_s = 4'hF;
      for (int e = 0; e < n_edges; e++) begin
         v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         pr = 7'(idx + 1);
         pg = 7'(idx * 3 + 5);
         pb = 7'(~idx);
         ps = 4'(idx);
         drive(1'b0, v, pr, pg, pb, ps);
         exp_rdy = ~m_full;
         chk($sformatf("%s ready e%0d", tag, e), {7'd0, pix_ready}, {7'd0, exp_rdy});
         if (v && pix_ready) dut_acc++;
         if (ph == 0) begin
            if (m_full) begin
               s_r = m_r; s_g = m_g; s_b = m_b; s_s = m_s; m_full = 1'b0;
            end else begin
               s_r = '0; s_g = '0; s_b = '0; s_s = m_last; m_uf = 1'b1;
            end
            m_last = s_s;
            exp_nd = 1'b0; exp_d = {3'b000, s_s};
         end else begin
            exp_nd = 1'b1;
            exp_d  = (ph == 1) ? s_r : (ph == 2) ? s_g : s_b;
         end
         if (v && exp_rdy) begin
            m_r = pr; m_g = pg; m_b = pb; m_s = ps; m_full = 1'b1; idx++;
         end
         ph = (ph + 1) % 4;
         edge_wait();
         chk($sformatf("%s nDSYNC e%0d", tag, e), {7'd0, nDSYNC}, {7'd0, exp_nd});
         chk($sformatf("%s D e%0d", tag, e), {1'b0, d}, {1'b0, exp_d});
         chk($sformatf("%s underflow e%0d", tag, e), {7'd0, underflow}, {7'd0, m_uf});
      end
   endtask

   initial begin
      int acc;
      // two reset edges, then continuous pixel P
      add(1,0, 7'h00,7'h00,7'h00,4'h0, 0, 1,7'h00,0);
      add(1,1, 7'h11,7'h22,7'h33,4'hF, 0, 1,7'h00,0);
      add(0,1, 7'h11,7'h22,7'h33,4'hF, 1, 0,7'h0F,1);
      add(0,1, 7'h11,7'h22,7'h33,4'hF, 0, 1,7'h00,1);
      add(0,1, 7'h11,7'h22,7'h33,4'hF, 0, 1,7'h00,1);
      add(0,1, 7'h11,7'h22,7'h33,4'hF, 0, 1,7'h00,1);
      add(0,1, 7'h11,7'h22,7'h33,4'hF, 0, 0,7'h0F,1);
      add(0,1, 7'h11,7'h22,7'h33,4'hF, 1, 1,7'h11,1);
      add(0,1, 7'h11,7'h22,7'h33,4'hF, 0, 1,7'h22,1);
      add(0,1, 7'h11,7'h22,7'h33,4'hF, 0, 1,7'h33,1);
      add(0,1, 7'h11,7'h22,7'h33,4'hF, 0, 0,7'h0F,1);
      add(0,1, 7'h11,7'h22,7'h33,4'hF, 1, 1,7'h11,1);
      add(0,1, 7'h11,7'h22,7'h33,4'hF, 0, 1,7'h22,1);
      add(0,1, 7'h11,7'h22,7'h33,4'hF, 0, 1,7'h33,1);
      // offer Q with sync A, then drop valid: Q slot then an underflow slot repeating A
      add(0,1, 7'h05,7'h06,7'h07,4'hA, 0, 0,7'h0F,1);
      add(0,1, 7'h05,7'h06,7'h07,4'hA, 1, 1,7'h11,1);
      add(0,0, 7'h00,7'h00,7'h00,4'h0, 0, 1,7'h22,1);
      add(0,0, 7'h00,7'h00,7'h00,4'h0, 0, 1,7'h33,1);
      add(0,0, 7'h00,7'h00,7'h00,4'h0, 0, 0,7'h0A,1);
      add(0,0, 7'h00,7'h00,7'h00,4'h0, 1, 1,7'h05,1);
      add(0,0, 7'h00,7'h00,7'h00,4'h0, 1, 1,7'h06,1);
      add(0,0, 7'h00,7'h00,7'h00,4'h0, 1, 1,7'h07,1);
      add(0,0, 7'h00,7'h00,7'h00,4'h0, 1, 0,7'h0A,1);
      add(0,0, 7'h00,7'h00,7'h00,4'h0, 1, 1,7'h00,1);
      add(0,0, 7'h00,7'h00,7'h00,4'h0, 1, 1,7'h00,1);
      add(0,0, 7'h00,7'h00,7'h00,4'h0, 1, 1,7'h00,1);
      // accept Q during an underflow slot, then reset at phase 2 discards it
      add(0,1, 7'h05,7'h06,7'h07,4'hA, 1, 0,7'h0A,1);
      add(0,0, 7'h00,7'h00,7'h00,4'h0, 0, 1,7'h00,1);
      add(1,0, 7'h00,7'h00,7'h00,4'h0, 0, 1,7'h00,0);
      add(0,0, 7'h00,7'h00,7'h00,4'h0, 1, 0,7'h0F,1);
      add(0,0, 7'h00,7'h00,7'h00,4'h0, 1, 1,7'h00,1);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].vld, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].sync);
         chk($sformatf("vec%0d ready", i), {7'd0, pix_ready}, {7'd0, vecs[i].ready});
         edge_wait();
         chk($sformatf("vec%0d nDSYNC", i), {7'd0, nDSYNC}, {7'd0, vecs[i].nd});
         chk($sformatf("vec%0d D", i), {1'b0, d}, {1'b0, vecs[i].d});
         chk($sformatf("vec%0d underflow", i), {7'd0, underflow}, {7'd0, vecs[i].uf});
      end

      // valid held high for 400 edges: pixels accepted at edges 0,5,9,..,397
      drive(1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 4'd0);
      edge_wait();
      model_run(400, 1'b0, "held", acc);
      chk("held accepted count", 8'(acc), 8'd100);

      // random valid against the model
      drive(1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 4'd0);
      edge_wait();
      model_run(240, 1'b1, "rand", acc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
